// File: rtl/dmi_pkg.sv
// DMI bus widths, op/response codes shared with the DTMs, and the
// encoding of the DMI arbiter FSM.
package dmi_pkg;

  localparam int unsigned DEBUG_DATA_BITS = 32;
  localparam int unsigned DEBUG_ADDR_BITS = 7;
  localparam int unsigned DEBUG_OP_BITS   = 2;
  localparam int unsigned DBUS_REQ_BITS   = DEBUG_OP_BITS + DEBUG_ADDR_BITS + DEBUG_DATA_BITS;
  localparam int unsigned DBUS_RESP_BITS  = DEBUG_OP_BITS + DEBUG_DATA_BITS;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2
  } t_dmi_op;

  typedef enum logic [1:0] {
    DMI_RESP_OK   = 2'd0,
    DMI_RESP_ERR  = 2'd2,
    DMI_RESP_BUSY = 2'd3
  } t_dmi_resp;

  // Legacy numeric encodings kept so existing state decoders keep matching.
  localparam logic [1:0] ARB_ST_IDLE = 2'd0;
  localparam logic [1:0] ARB_ST_REQ  = 2'd1;
  localparam logic [1:0] ARB_ST_RSP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ARB_ST_IDLE,
    REQ  = ARB_ST_REQ,
    RSP  = ARB_ST_RSP
  } t_dmi_arb_state;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin winner: scans requests starting one past
// last_gnt and wrapping; reusable for any shared-resource arbiter.
module rr_arbiter_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int unsigned c;
    c   = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      c = (32'(last_gnt) + i) % N;
      if (!any && req[c]) begin
        any = 1'b1;
        idx = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// Shares one DM DMI slave port between N_MASTERS DTMs, one transaction at a
// time, round-robin. Define DMI_ARB_LOCK_EN to honour m_lock.
module dmi_arbiter #(
  parameter int unsigned N_MASTERS       = 2,
  parameter int unsigned DEBUG_DATA_BITS = dmi_pkg::DEBUG_DATA_BITS,
  parameter int unsigned DEBUG_ADDR_BITS = dmi_pkg::DEBUG_ADDR_BITS,
  parameter int unsigned DEBUG_OP_BITS   = dmi_pkg::DEBUG_OP_BITS,
  parameter int unsigned DBUS_REQ_BITS   = DEBUG_OP_BITS + DEBUG_ADDR_BITS + DEBUG_DATA_BITS,
  parameter int unsigned DBUS_RESP_BITS  = DEBUG_OP_BITS + DEBUG_DATA_BITS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_MASTERS-1:0]               m_req_valid,
  output logic [N_MASTERS-1:0]               m_req_ready,
  input  logic [N_MASTERS*DBUS_REQ_BITS-1:0] m_req_bits,
  output logic [N_MASTERS-1:0]               m_resp_valid,
  input  logic [N_MASTERS-1:0]               m_resp_ready,
  output logic [DBUS_RESP_BITS-1:0]          m_resp_bits,
  input  logic [N_MASTERS-1:0]               m_lock,
  output logic                               dm_req_valid,
  input  logic                               dm_req_ready,
  output logic [DBUS_REQ_BITS-1:0]           dm_req_bits,
  input  logic                               dm_resp_valid,
  output logic                               dm_resp_ready,
  input  logic [DBUS_RESP_BITS-1:0]          dm_resp_bits,
  output logic [N_MASTERS-1:0]               grant,
  output logic                               busy
);

  import dmi_pkg::*;

  localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  t_dmi_arb_state       state;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     last_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [N_MASTERS-1:0] eligible;
  logic                 resp_phase;
  logic                 done;
  logic                 rr_frozen;

`ifdef DMI_ARB_LOCK_EN
  logic             locked;
  logic [IDX_W-1:0] lock_owner;
  logic             lock_hold;

  // Lock is released in the same IDLE cycle the owner drops m_lock.
  assign lock_hold = locked && m_lock[lock_owner];
  assign rr_frozen = locked;

  always_comb begin
    eligible = m_req_valid;
    if (lock_hold) begin
      eligible             = '0;
      eligible[lock_owner] = m_req_valid[lock_owner];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked     <= 1'b0;
      lock_owner <= '0;
    end else if (state == IDLE && locked && !m_lock[lock_owner]) begin
      locked <= 1'b0;
    end else if (done && m_lock[gnt_idx]) begin
      locked     <= 1'b1;
      lock_owner <= gnt_idx;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^m_lock;
  assign rr_frozen   = 1'b0;
  assign eligible    = m_req_valid;
`endif

  rr_arbiter_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (eligible),
    .last_gnt (last_gnt),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // A response can only be taken once the request has been accepted,
  // which in REQ means in the same cycle as dm_req_ready.
  assign resp_phase = (state == RSP) || (state == REQ && dm_req_ready);
  assign done       = resp_phase && dm_resp_valid && m_resp_ready[gnt_idx];

  always_comb begin
    dm_req_valid  = (state == REQ);
    dm_req_bits   = m_req_bits[gnt_idx*DBUS_REQ_BITS +: DBUS_REQ_BITS];
    dm_resp_ready = resp_phase && m_resp_ready[gnt_idx];
    m_resp_bits   = dm_resp_bits;
    m_req_ready   = '0;
    m_resp_valid  = '0;
    grant         = '0;
    busy          = (state != IDLE);
    if (state != IDLE) begin
      grant[gnt_idx] = 1'b1;
    end
    if (state == REQ) begin
      m_req_ready[gnt_idx] = dm_req_ready;
    end
    if (resp_phase) begin
      m_resp_valid[gnt_idx] = dm_resp_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      last_gnt <= IDX_W'(N_MASTERS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_idx <= pick_idx;
            state   <= REQ;
          end
        end
        REQ, RSP: begin
          if (done) begin
            state <= IDLE;
            if (!rr_frozen) begin
              last_gnt <= gnt_idx;
            end
          end else if (state == REQ && dm_req_ready) begin
            state <= RSP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Self-checking bench for dmi_arbiter: cycle tables for directed scenarios,
// hand sequences for reset/lock, and random traffic against a reference model.
module tb_dmi_arbiter;

  import dmi_pkg::*;

  localparam int unsigned NM = 3;
  localparam int unsigned RQ = DBUS_REQ_BITS;
  localparam int unsigned RS = DBUS_RESP_BITS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NM-1:0]     m_req_valid, m_req_ready, m_resp_valid, m_resp_ready, m_lock, grant;
  logic [NM*RQ-1:0]  m_req_bits;
  logic [RS-1:0]     m_resp_bits, dm_resp_bits;
  logic [RQ-1:0]     dm_req_bits;
  logic              dm_req_valid, dm_req_ready, dm_resp_valid, dm_resp_ready, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmi_arbiter #(.N_MASTERS(NM)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_req_valid   (m_req_valid),
    .m_req_ready   (m_req_ready),
    .m_req_bits    (m_req_bits),
    .m_resp_valid  (m_resp_valid),
    .m_resp_ready  (m_resp_ready),
    .m_resp_bits   (m_resp_bits),
    .m_lock        (m_lock),
    .dm_req_valid  (dm_req_valid),
    .dm_req_ready  (dm_req_ready),
    .dm_req_bits   (dm_req_bits),
    .dm_resp_valid (dm_resp_valid),
    .dm_resp_ready (dm_resp_ready),
    .dm_resp_bits  (dm_resp_bits),
    .grant         (grant),
    .busy          (busy)
  );

  typedef struct {
    logic [NM-1:0] mv, mrr;
    logic          drr, drv;
    logic [NM-1:0] e_grant;
    logic          e_dv;
    logic [NM-1:0] e_mreq_rdy, e_mresp_v;
    logic          e_drr, e_busy;
  } vec_t;

  vec_t          vecs[$];
  logic [RQ-1:0] req_w [NM];
  logic [RS-1:0] resp_w;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RQ-1:0] mk_req(input logic [6:0] a, input logic [31:0] d, input t_dmi_op op);
    return {a, d, op};
  endfunction

  function automatic vec_t row(input logic [NM-1:0] mv, input logic [NM-1:0] mrr, input logic drr,
                               input logic drv, input logic [NM-1:0] eg, input logic edv,
                               input logic [NM-1:0] emq, input logic [NM-1:0] emr,
                               input logic edr, input logic eb);
    vec_t v;
    v.mv = mv; v.mrr = mrr; v.drr = drr; v.drv = drv;
    v.e_grant = eg; v.e_dv = edv; v.e_mreq_rdy = emq; v.e_mresp_v = emr;
    v.e_drr = edr; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".grant"}, 64'(grant), 64'(0));
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".dm_req_valid"}, 64'(dm_req_valid), 64'(0));
    chk({tag, ".dm_resp_ready"}, 64'(dm_resp_ready), 64'(0));
    chk({tag, ".m_req_ready"}, 64'(m_req_ready), 64'(0));
    chk({tag, ".m_resp_valid"}, 64'(m_resp_valid), 64'(0));
  endtask

  task automatic drive_zero();
    m_req_valid = '0; m_resp_ready = '0; m_lock = '0;
    dm_req_ready = 1'b0; dm_resp_valid = 1'b0;
  endtask

  // Leaves the bench 1 time unit after a rising edge, DUT freshly out of reset.
  task automatic do_reset();
    rst_n = 1'b0;
    drive_zero();
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifdef DMI_ARB_LOCK_EN
  task automatic lock_txn(input logic [NM-1:0] mv, input logic [NM-1:0] lk, input logic [NM-1:0] eg,
                          input string tag);
    m_req_valid = mv; m_lock = lk; dm_req_ready = 1'b0; dm_resp_valid = 1'b0; m_resp_ready = '1;
    #1;
    chk({tag, ".idle_grant"}, 64'(grant), 64'(0));
    @(posedge clk); #1;
    dm_req_ready = 1'b1; dm_resp_valid = 1'b1;
    #1;
    chk({tag, ".grant"}, 64'(grant), 64'(eg));
    @(posedge clk); #1;
    dm_req_ready = 1'b0; dm_resp_valid = 1'b0;
  endtask
`endif

  // Reference model: which master owns the port, whether its request was taken.
  int            owner, last;
  bit            accepted;
  bit [NM-1:0]   pend;
  logic [RQ-1:0] word [NM];

  initial begin
    rst_n = 1'b0;
    drive_zero();
    m_req_bits   = '0;
    dm_resp_bits = '0;

    req_w[0] = mk_req(7'h11, 32'h0000_0000, DMI_OP_READ);
    req_w[1] = mk_req(7'h22, 32'hCAFE_F00D, DMI_OP_WRITE);
    req_w[2] = mk_req(7'h33, 32'h1234_5678, DMI_OP_READ);
    resp_w   = {32'hDEAD_BEEF, DMI_RESP_OK};

    // Reset state, with requests already pending.
    m_req_valid = '1;
    #3;
    chk_idle_outputs("reset");
    m_req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NM; i++) m_req_bits[i*RQ +: RQ] = req_w[i];
    dm_resp_bits = resp_w;

    // Contention 0/1 with same-cycle accept+response.
    for (int k = 0; k < 2; k++) begin
      vecs.push_back(row(3'b011, 3'b111, 1, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0));
      vecs.push_back(row(3'b011, 3'b111, 1, 1, 3'b001, 1, 3'b001, 3'b001, 1, 1));
      vecs.push_back(row(3'b011, 3'b111, 1, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0));
      vecs.push_back(row(3'b011, 3'b111, 1, 1, 3'b010, 1, 3'b010, 3'b010, 1, 1));
    end
    // Single master read, response 3 cycles after accept.
    vecs.push_back(row(3'b001, 3'b111, 0, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0));
    vecs.push_back(row(3'b001, 3'b111, 0, 0, 3'b001, 1, 3'b000, 3'b000, 0, 1));
    vecs.push_back(row(3'b001, 3'b111, 1, 0, 3'b001, 1, 3'b001, 3'b000, 1, 1));
    vecs.push_back(row(3'b000, 3'b111, 0, 0, 3'b001, 0, 3'b000, 3'b000, 1, 1));
    vecs.push_back(row(3'b000, 3'b111, 0, 0, 3'b001, 0, 3'b000, 3'b000, 1, 1));
    vecs.push_back(row(3'b000, 3'b111, 0, 1, 3'b001, 0, 3'b000, 3'b001, 1, 1));
    vecs.push_back(row(3'b000, 3'b111, 0, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0));
    // Master 1 backpressures its response for 5 cycles while master 0 waits.
    vecs.push_back(row(3'b010, 3'b111, 0, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0));
    vecs.push_back(row(3'b010, 3'b101, 1, 1, 3'b010, 1, 3'b010, 3'b010, 0, 1));
    for (int k = 0; k < 4; k++)
      vecs.push_back(row(3'b001, 3'b101, 0, 1, 3'b010, 0, 3'b000, 3'b010, 0, 1));
    vecs.push_back(row(3'b001, 3'b111, 0, 1, 3'b010, 0, 3'b000, 3'b010, 1, 1));
    vecs.push_back(row(3'b001, 3'b111, 0, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0));
    vecs.push_back(row(3'b001, 3'b111, 1, 1, 3'b001, 1, 3'b001, 3'b001, 1, 1));
    vecs.push_back(row(3'b000, 3'b111, 0, 0, 3'b000, 0, 3'b000, 3'b000, 0, 0));

    foreach (vecs[k]) begin
      m_req_valid = vecs[k].mv; m_resp_ready = vecs[k].mrr;
      dm_req_ready = vecs[k].drr; dm_resp_valid = vecs[k].drv;
      #1;
      chk($sformatf("vec%0d.grant", k), 64'(grant), 64'(vecs[k].e_grant));
      chk($sformatf("vec%0d.busy", k), 64'(busy), 64'(vecs[k].e_busy));
      chk($sformatf("vec%0d.dm_req_valid", k), 64'(dm_req_valid), 64'(vecs[k].e_dv));
      chk($sformatf("vec%0d.m_req_ready", k), 64'(m_req_ready), 64'(vecs[k].e_mreq_rdy));
      chk($sformatf("vec%0d.m_resp_valid", k), 64'(m_resp_valid), 64'(vecs[k].e_mresp_v));
      chk($sformatf("vec%0d.dm_resp_ready", k), 64'(dm_resp_ready), 64'(vecs[k].e_drr));
      for (int i = 0; i < NM; i++)
        if (vecs[k].e_dv && vecs[k].e_grant[i])
          chk($sformatf("vec%0d.dm_req_bits", k), 64'(dm_req_bits), 64'(req_w[i]));
      if (vecs[k].e_mresp_v != '0)
        chk($sformatf("vec%0d.m_resp_bits", k), 64'(m_resp_bits), 64'(resp_w));
      @(posedge clk); #1;
    end

    // Reset in RSP: master 1 owns the port (last winner was 0).
    m_req_valid = 3'b010; dm_req_ready = 1'b0; dm_resp_valid = 1'b0; m_resp_ready = '0;
    @(posedge clk); #1;
    dm_req_ready = 1'b1;
    @(posedge clk); #1;
    m_req_valid = '0; dm_req_ready = 1'b0; dm_resp_valid = 1'b1;
    #1;
    chk("rstmid.pre_grant", 64'(grant), 64'(3'b010));
    chk("rstmid.pre_m_resp_valid", 64'(m_resp_valid), 64'(3'b010));
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rstmid");
    dm_resp_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_req_valid = 3'b011;
    #1;
    chk("rstmid.post_idle_grant", 64'(grant), 64'(0));
    @(posedge clk); #1;
    chk("rstmid.first_winner", 64'(grant), 64'(3'b001));
    dm_req_ready = 1'b1; dm_resp_valid = 1'b1; m_resp_ready = '1;
    @(posedge clk); #1;

`ifdef DMI_ARB_LOCK_EN
    do_reset();
    lock_txn(3'b010, 3'b010, 3'b010, "lock1");
    lock_txn(3'b011, 3'b010, 3'b010, "lock2");
    lock_txn(3'b011, 3'b010, 3'b010, "lock3");
    lock_txn(3'b001, 3'b000, 3'b001, "unlock");
`endif

    // Random traffic against the reference model.
    do_reset();
    owner = -1; last = NM - 1; accepted = 0; pend = '0;
    for (int i = 0; i < NM; i++) word[i] = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit resp_ph, found;
      for (int i = 0; i < NM; i++)
        if (!pend[i] && ($urandom_range(2) == 0)) begin
          pend[i] = 1'b1;
          word[i] = RQ'({$urandom(), $urandom()});
        end
      for (int i = 0; i < NM; i++) m_req_bits[i*RQ +: RQ] = word[i];
      m_req_valid   = pend;
      m_resp_ready  = NM'($urandom());
      dm_req_ready  = ($urandom_range(2) != 0);
      resp_ph       = (owner >= 0) && (accepted || dm_req_ready);
      dm_resp_valid = resp_ph && ($urandom_range(1) == 1);
      dm_resp_bits  = RS'({$urandom(), $urandom()});
      #1;
      chk("rnd.grant", 64'(grant), (owner >= 0) ? 64'(1) << owner : 64'(0));
      chk("rnd.busy", 64'(busy), 64'(owner >= 0));
      chk("rnd.dm_req_valid", 64'(dm_req_valid), 64'(owner >= 0 && !accepted));
      if (owner >= 0 && !accepted)
        chk("rnd.dm_req_bits", 64'(dm_req_bits), 64'(word[owner]));
      chk("rnd.m_req_ready", 64'(m_req_ready),
          (owner >= 0 && !accepted && dm_req_ready) ? 64'(1) << owner : 64'(0));
      chk("rnd.m_resp_valid", 64'(m_resp_valid),
          (resp_ph && dm_resp_valid) ? 64'(1) << owner : 64'(0));
      chk("rnd.dm_resp_ready", 64'(dm_resp_ready),
          64'(resp_ph && m_resp_ready[(owner >= 0) ? owner : 0]));
      chk("rnd.m_resp_bits", 64'(m_resp_bits), 64'(dm_resp_bits));

      if (owner < 0) begin
        found = 0;
        for (int s = 1; s <= NM; s++) begin
          int c;
          c = (last + s) % NM;
          if (!found && pend[c]) begin
            found = 1;
            owner = c;
          end
        end
      end else begin
        if (!accepted && dm_req_ready) begin
          accepted    = 1;
          pend[owner] = 1'b0;
        end
        if (resp_ph && dm_resp_valid && m_resp_ready[owner]) begin
          last     = owner;
          owner    = -1;
          accepted = 0;
        end
      end
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmi_arbiter.md
# dmi_arbiter

Shares a single Debug Module DMI slave port between `N_MASTERS` DMI requesters, for example the JTAG DTM and the ICB-controlled DTM. The arbiter sits between the DTMs and the DM. It allows one outstanding transaction at a time and grants masters round-robin. A grant is held from request acceptance until the response handshake completes, and the response is routed back only to the granted master.

## Interface
- `N_MASTERS`, 2: number of DMI requesters (2..8).
- `DEBUG_DATA_BITS`, 32: DMI data width.
- `DEBUG_ADDR_BITS`, 7: DMI address width.
- `DEBUG_OP_BITS`, 2: op/response code width.
- `DBUS_REQ_BITS`, OP+ADDR+DATA: request bus width.
- `DBUS_RESP_BITS`, OP+DATA: response bus width.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `m_req_valid` in N_MASTERS: per-master request valid.
- `m_req_ready` out N_MASTERS: per-master request ready.
- `m_req_bits` in N_MASTERS×DBUS_REQ_BITS: per-master request, packed with master i in slice i.
- `m_resp_valid` out N_MASTERS: per-master response valid.
- `m_resp_ready` in N_MASTERS: per-master response ready.
- `m_resp_bits` out DBUS_RESP_BITS: response data, broadcast to all masters and qualified by `m_resp_valid`.
- `m_lock` in N_MASTERS: per-master lock request. Only effective with `DMI_ARB_LOCK_EN`.
- `dm_req_valid` out 1, `dm_req_ready` in 1, `dm_req_bits` out DBUS_REQ_BITS: request port toward the DM.
- `dm_resp_valid` in 1, `dm_resp_ready` out 1, `dm_resp_bits` in DBUS_RESP_BITS: response port from the DM.
- `grant` out N_MASTERS: one-hot current owner; 0 when idle.
- `busy` out 1: a transaction is in flight.

## Operation
- FSM states:
  - `IDLE`: no transaction in flight. If any eligible `m_req_valid` is high, register the round-robin winner into `gnt_idx` and go to `REQ`.
  - `REQ`: drive `dm_req_valid=1` and `dm_req_bits=m_req_bits[gnt_idx]`; `m_req_ready[gnt_idx]=dm_req_ready`.
    - On `dm_req_ready`: if `dm_resp_valid` and `m_resp_ready[gnt_idx]` are also high, the transaction completes; otherwise go to `RSP`.
  - `RSP`: forward `m_resp_valid[gnt_idx]=dm_resp_valid` and `dm_resp_ready=m_resp_ready[gnt_idx]`. The transaction completes when both are high.
  - On completion go to `IDLE` and set `last_gnt=gnt_idx`.
- Round-robin: search order starts at `(last_gnt+1) mod N_MASTERS` and wraps. `last_gnt` resets to `N_MASTERS-1`, so master 0 wins first.
- Non-granted masters see `m_req_ready=0` and `m_resp_valid=0`. Their requests stay pending, and each master must hold `m_req_valid` until it sees ready.
- `dm_resp_ready=0` outside `REQ`/`RSP`. A `dm_resp_valid` arriving in `IDLE` is not acknowledged (protocol error; the bench flags it).
- `grant` is one-hot of `gnt_idx` in `REQ`/`RSP` and 0 in `IDLE`. `busy` is 1 whenever the state is not `IDLE`.
- A master dropping `m_req_valid` while in `REQ` is a protocol violation. The arbiter keeps driving the captured `gnt_idx` and does not abort.

## Timing
- Reset values:
  - `dm_req_valid=0`, `dm_resp_ready=0`.
  - `m_req_ready=0`, `m_resp_valid=0`.
  - `grant=0`, `busy=0`, state `IDLE`, `last_gnt=N_MASTERS-1`.
- Arbitration latency is 1 cycle: a request seen in `IDLE` at cycle t gives `dm_req_valid=1` at t+1.
- The request and response paths from DM to master are combinational pass-through, with no added latency.
- Minimum transaction is 2 cycles (`IDLE`→`REQ`, with accept and response in the same cycle). Back-to-back transactions spend 1 `IDLE` cycle between them.
- Simultaneous requests: exactly one grant, by round-robin order. Masters 0 and 1 requesting continuously alternate 0,1,0,1.
- Reset mid-transaction: asynchronous return to `IDLE`. A DM response in flight is dropped, and the DM must be reset alongside.

## Configuration
- `DMI_ARB_LOCK_EN` defined:
  - If `m_lock[gnt_idx]` is high at completion, the FSM sets `locked` and records `lock_owner=gnt_idx`.
  - While `locked`, only `lock_owner` is eligible in `IDLE`, and `last_gnt` is not advanced.
  - `locked` clears in any `IDLE` cycle where `m_lock[lock_owner]=0`; normal arbitration resumes that same cycle.
  - `locked` resets to 0.
- `DMI_ARB_LOCK_EN` undefined: the `m_lock` ports remain but are ignored, and no lock registers are implemented.

## Structure
- Package `dmi_pkg`:
  - width constants (DATA/ADDR/OP, REQ/RESP bits);
  - the `t_dmi_arb_state` enum {`IDLE`, `REQ`, `RSP`};
  - the op/response code enums shared with the DTMs.
- Sub-module `rr_arbiter_pick`: combinational round-robin winner. Inputs are the request vector and `last_gnt`; outputs are the winner index and `any`. It is reusable by other shared-resource arbiters.

## Test plan
- Single master: master 0 issues a read to addr 0x11. `dm_req_valid` rises 1 cycle later. DM responds `{OK, 0xDEADBEEF}` after 3 cycles → only `m_resp_valid[0]` pulses, with bits 0xDEADBEEF/OK.
- Contention: masters 0 and 1 each request continuously for 4 transactions → `grant` sequence 01,10,01,10, and no overlapping `busy` periods.
- Same-cycle accept and response: DM asserts `dm_req_ready` and `dm_resp_valid` together → completes in `REQ`, and the next grant follows after one `IDLE` cycle.
- Backpressure: `m_resp_ready[1]=0` for 5 cycles → `dm_resp_ready` stays 0, the state holds `RSP`, and there is no grant change.
- Reset mid-op: assert `rst_n=0` in `RSP` → all outputs return to their reset values asynchronously, and master 0 wins the first request afterwards.
- Lock (`DMI_ARB_LOCK_EN`): master 1 holds `m_lock` for 3 transactions while master 0 requests → grants go 1,1,1 then 0 after master 1 drops lock.
